// File: rtl/zbt_arbiter_pkg.sv
// Shared ZBT memory-interface constants and arbiter grant encoding.
// The ZBT model and the arbiter both take their bus widths from here.
package zbt_arbiter_pkg;

    localparam int ZBT_LOG_ADDR = 19;
    localparam int ZBT_LOG_MEM  = 36;

    // One ZBT operation (or none) is granted per cycle.
    typedef enum logic [1:0] {
        GNT_IDLE   = 2'd0,
        GNT_READ   = 2'd1,
        GNT_WRITE  = 2'd2,
        GNT_FORCED = 2'd3
    } grant_e;

    function automatic logic grant_is_write(input grant_e g);
        return (g == GNT_WRITE) || (g == GNT_FORCED);
    endfunction

endpackage

// File: rtl/zbt_write_fifo.sv
// Write buffer for the ZBT arbiter; exposes every entry's address and valid
// bit so the arbiter can detect read-after-write hazards.
module zbt_write_fifo
    import zbt_arbiter_pkg::*;
#(
    parameter int LOG_ADDR = ZBT_LOG_ADDR,
    parameter int LOG_MEM  = ZBT_LOG_MEM,
    parameter int DEPTH    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic [LOG_ADDR-1:0]       push_addr,
    input  logic [LOG_MEM-1:0]        push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [LOG_ADDR-1:0]       head_addr,
    output logic [LOG_MEM-1:0]        head_data,
    output logic [DEPTH*LOG_ADDR-1:0] entry_addr,
    output logic [DEPTH-1:0]          entry_valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [LOG_ADDR-1:0] addr_mem [DEPTH];
    logic [LOG_MEM-1:0]  data_mem [DEPTH];
    logic [DEPTH-1:0]    valid_q;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count_q;
    logic                do_push;
    logic                do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_addr   = addr_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];
    assign entry_valid = valid_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign entry_addr[g*LOG_ADDR +: LOG_ADDR] = addr_mem[g];
    end

    // Push and pop never target the same slot: pop needs an entry, push needs room.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                valid_q[wr_ptr]  <= 1'b1;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/zbt_arbiter.sv
// Single-port ZBT arbiter: buffered writes, hazard-checked reads, bounded
// read starvation of writes, and a fixed-latency read return path.
module zbt_arbiter
    import zbt_arbiter_pkg::*;
#(
    parameter int LOG_ADDR   = ZBT_LOG_ADDR,
    parameter int LOG_MEM    = ZBT_LOG_MEM,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8,
    parameter int READ_LAT   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_req,
    input  logic [LOG_ADDR-1:0] wr_addr,
    input  logic [LOG_MEM-1:0]  wr_data,
    output logic                wr_ready,
    input  logic                rd_req,
    input  logic [LOG_ADDR-1:0] rd_addr,
    output logic                rd_ready,
    output logic                rd_valid,
    output logic [LOG_MEM-1:0]  rd_data,
    output logic                mem_wr,
    output logic [LOG_ADDR-1:0] mem_addr,
    output logic [LOG_MEM-1:0]  mem_write,
    input  logic [LOG_MEM-1:0]  mem_data
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    logic                           fifo_full;
    logic                           fifo_empty;
    logic [LOG_ADDR-1:0]            head_addr;
    logic [LOG_MEM-1:0]             head_data;
    logic [FIFO_DEPTH*LOG_ADDR-1:0] entry_addr;
    logic [FIFO_DEPTH-1:0]          entry_valid;
    logic                           hazard;
    logic                           fifo_pop;
    grant_e                         grant;
    logic [SC_W-1:0]                starve_cnt;
    logic [READ_LAT:0]              rd_pipe;

    assign wr_ready = !fifo_full;

    zbt_write_fifo #(
        .LOG_ADDR (LOG_ADDR),
        .LOG_MEM  (LOG_MEM),
        .DEPTH    (FIFO_DEPTH)
    ) u_write_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (wr_req),
        .push_addr   (wr_addr),
        .push_data   (wr_data),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_addr  (entry_addr),
        .entry_valid (entry_valid)
    );

    // Registered FIFO contents exclude this cycle's push, so a same-cycle
    // write never stalls a read to its address.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i*LOG_ADDR +: LOG_ADDR] == rd_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        grant = GNT_IDLE;
        if ((starve_cnt == STARVE_LIM) && !fifo_empty) begin
            grant = GNT_FORCED;
        end else if (rd_req && !hazard) begin
            grant = GNT_READ;
        end else if (!fifo_empty) begin
            grant = GNT_WRITE;
        end
    end

    assign fifo_pop = grant_is_write(grant);
    assign rd_ready = rd_req && (grant == GNT_READ);

    // Counts reads that bypassed pending writes; saturates at the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (fifo_empty || grant_is_write(grant)) begin
            starve_cnt <= '0;
        end else if ((grant == GNT_READ) && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_write <= '0;
        end else begin
            mem_wr <= grant_is_write(grant);
            case (grant)
                GNT_READ: begin
                    mem_addr <= rd_addr;
                end
                GNT_WRITE, GNT_FORCED: begin
                    mem_addr  <= head_addr;
                    mem_write <= head_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Stage 0 lines up with the read address on mem_addr; stage READ_LAT
    // marks the cycle in which mem_data carries the word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_pipe  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_pipe  <= {rd_pipe[READ_LAT-1:0], (grant == GNT_READ)};
            rd_valid <= rd_pipe[READ_LAT];
            if (rd_pipe[READ_LAT]) begin
                rd_data <= mem_data;
            end
        end
    end

endmodule
